io_input_conditioner: RTL and testbench
=======================================

# io_input_conditioner

Parametrised front end for the Cu board's DIP switches and push buttons, replacing `emulate_pull_down`. For each channel it emulates a weak pull-down or pull-up, since the FPGA has no internal pull-down resistors. It then synchronises, debounces and edge-detects the pad, and delivers a clean level plus one-cycle press and release pulses. It sits between the top-level `inout` pads and user logic, with one instance per pad group.

## Interface
- `SIZE`, 24: number of channels.
- `EMULATE`, all ones: per-channel mask. 1 means the channel takes part in the bias drive; 0 means the pad is never driven and is only sampled.
- `ACTIVE_LOW`, 0: per-channel mask. 1 means bias high (emulated pull-up) and report `level = ~pad`. 0 means bias low and report `level = pad`.
- `DRIVE_CYCLES`, 4: cycles the bias value is driven onto emulated pads. Must be ≥ 1.
- `SETTLE_CYCLES`, 16: cycles between releasing the pad and sampling it. Must be ≥ 3.
- `DEBOUNCE_SAMPLES`, 8: consecutive differing samples needed to flip `level`. Must be ≥ 1.

Ports:
- `clk`, in, 1: system clock (100 MHz).
- `rst_n`, in, 1: asynchronous, active-low reset.
- `pad`, inout, SIZE: board pins.
- `level`, out, SIZE: debounced, polarity-corrected state. 1 means active.
- `rise`, out, SIZE: one-cycle pulse when `level` goes 0→1.
- `fall`, out, SIZE: one-cycle pulse when `level` goes 1→0.
- `sample_tick`, out, 1: one-cycle pulse in the SAMPLE state, for bench and diagnostic use.

## Operation
- A single scan FSM is shared by all channels: DRIVE → RELEASE → SAMPLE → DRIVE, with a phase counter of width clog2(max(DRIVE_CYCLES, SETTLE_CYCLES)).
- **DRIVE** lasts DRIVE_CYCLES cycles.
  - Emulated pads are output-enabled and driven with the value `ACTIVE_LOW[i]`.
  - Other pads are Z.
- **RELEASE** lasts SETTLE_CYCLES cycles. All pads are Z.
- **SAMPLE** lasts 1 cycle.
  - All pads are Z.
  - `sample_tick` = 1.
  - The synchroniser output is captured as `raw`.
- Every pad passes continuously through a 2-flop synchroniser. Its value during DRIVE is never used.
- Per channel, on each sample tick, with `s = raw[i] ^ ACTIVE_LOW[i]`:
  - If `s == level[i]`: clear the debounce counter.
  - Otherwise: increment the counter. When the counter reaches DEBOUNCE_SAMPLES, set `level[i] = s`, clear the counter, and pulse `rise[i]` if `s` = 1 or `fall[i]` if `s` = 0.
- The counter saturates and never wraps. It is clog2(DEBOUNCE_SAMPLES+1) bits wide.
- Channels are fully independent. Any number of channels may produce edges in the same cycle.
- Reset, whether asserted mid-scan or otherwise, does all of the following immediately:
  - pads go Z (all output enables 0);
  - the FSM enters DRIVE with the phase counter at 0;
  - `level`, `rise`, `fall`, `sample_tick`, all debounce counters and the synchroniser flops go to 0.
- After reset, an input that is already active is reported as a `rise` once DEBOUNCE_SAMPLES samples have been taken.

## Timing
- Scan period P = DRIVE_CYCLES + SETTLE_CYCLES + 1 cycles. `sample_tick` therefore fires every P cycles.
- The first tick after reset release falls in cycle DRIVE_CYCLES + SETTLE_CYCLES, counting from 0 at the first clock edge with `rst_n` high.
- Output-enable deasserts on the first RELEASE cycle. SETTLE_CYCLES ≥ 3 guarantees the synchroniser carries released-pad data by SAMPLE.
- Edge latency: the pad must be stable for DEBOUNCE_SAMPLES consecutive ticks. `level` changes, and `rise`/`fall` pulse, in the cycle after the Nth qualifying tick.
- A single glitched sample resets the count. Glitches shorter than (DEBOUNCE_SAMPLES−1)·P are fully rejected.
- `rise`/`fall` are high for exactly one cycle, and never both high on one channel.
- All outputs are registered.

## Structure
- A shared header `io_conditioner_defs.vh` holds the scan-state encodings (DRIVE = 2'd0, RELEASE = 2'd1, SAMPLE = 2'd2) and the clog2 helper macro.
- The natural sub-module is `debounce_channel`. It takes `clk`, `rst_n`, `tick` and `s`, and produces `level`, `rise` and `fall`, each 1 bit wide and parametrised by DEBOUNCE_SAMPLES. The top instantiates SIZE copies with a generate loop.
- The scan FSM, the tristate drivers and the synchronisers live in the top of the block.

## Test plan
All scenarios use SIZE=4, EMULATE=4'b0111, ACTIVE_LOW=4'b0100, DRIVE=2, SETTLE=4, DEBOUNCE=3, giving P=7.
- **Reset and scan:** with all pads floating (bench weak-pull to the bias value), run 50 cycles.
  - Ticks occur at cycles 6, 13, 20, ….
  - Pad output enables are 4'b0111 only in cycles ≡ 0–1 mod 7.
  - `level` stays 0.
- **Press:** drive `pad[0]` = 1 from cycle 10.
  - `rise[0]` pulses exactly once, in the cycle after the third tick at or after cycle 12.
  - `level[0]` = 1 thereafter.
- **Bounce rejection:** toggle `pad[1]` to 1 for one tick only, then back to 0.
  - No `rise[1]`.
  - The counter returns to 0.
  - A following stable press needs the full 3 ticks.
- **Active-low channel:** pull `pad[2]` to 0 → `rise[2]` after 3 ticks; return it to 1 → `fall[2]` after 3 ticks.
- **Non-emulated channel and simultaneous edges:** `pad[3]` is never driven. Press `pad[0]` and `pad[3]` on the same cycle → `rise[0]` and `rise[3]` pulse in the same cycle.
- **Reset mid-operation:** assert `rst_n` = 0 during RELEASE while `level` = 4'b0001.
  - Pads go Z and all outputs are 0 within the reset.
  - After release, with `pad[0]` still held, `rise[0]` re-fires after 3 ticks.

Source files
------------

// File: rtl/io_input_conditioner_pkg.sv
// Shared types and elaboration-time helpers for the pad input conditioner.
package io_input_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_DRIVE   = 2'd0,
    ST_RELEASE = 2'd1,
    ST_SAMPLE  = 2'd2
  } scan_state_e;

  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    while (r < 31 && (32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned max_f(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/io_input_conditioner_debounce_channel.sv
// One channel of the conditioner: counts disagreeing samples and flips the level.
module io_input_conditioner_debounce_channel
  import io_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SAMPLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic s,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = clog2_f(DEBOUNCE_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SAMPLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick) begin
      if (s == level_q) begin
        cnt_d = '0;
      end else if (cnt_q + CNT_W'(1) >= CNT_MAX) begin
        level_d = s;
        cnt_d   = '0;
        rise_d  = s;
        fall_d  = ~s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/io_input_conditioner.sv
// Pad front end: emulated weak bias, shared scan FSM, synchronisers and per-channel debounce.
module io_input_conditioner
  import io_input_conditioner_pkg::*;
#(
  parameter int unsigned     SIZE             = 24,
  parameter logic [SIZE-1:0] EMULATE          = '1,
  parameter logic [SIZE-1:0] ACTIVE_LOW       = '0,
  parameter int unsigned     DRIVE_CYCLES     = 4,
  parameter int unsigned     SETTLE_CYCLES    = 16,
  parameter int unsigned     DEBOUNCE_SAMPLES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  inout  wire [SIZE-1:0]  pad,
  output logic [SIZE-1:0] level,
  output logic [SIZE-1:0] rise,
  output logic [SIZE-1:0] fall,
  output logic            sample_tick
);

  localparam int unsigned PH_W = clog2_f(max_f(DRIVE_CYCLES, SETTLE_CYCLES));

  scan_state_e     state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [SIZE-1:0] pad_oe_q, pad_oe_d;
  logic            tick_q, tick_d;
  logic [SIZE-1:0] sync1_q, sync2_q;
  logic [SIZE-1:0] raw;
  logic [SIZE-1:0] s_vec;

  // Scan sequencing; enables and tick are registered from the next state.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + PH_W'(1);
    case (state_q)
      ST_DRIVE: begin
        if (phase_q == PH_W'(DRIVE_CYCLES - 1)) begin
          state_d = ST_RELEASE;
          phase_d = '0;
        end
      end
      ST_RELEASE: begin
        if (phase_q == PH_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_SAMPLE;
          phase_d = '0;
        end
      end
      default: begin
        state_d = ST_DRIVE;
        phase_d = '0;
      end
    endcase
    pad_oe_d = (state_d == ST_DRIVE) ? EMULATE : '0;
    tick_d   = (state_d == ST_SAMPLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_DRIVE;
      phase_q  <= '0;
      pad_oe_q <= '0;
      tick_q   <= 1'b0;
      sync1_q  <= '0;
      sync2_q  <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      pad_oe_q <= pad_oe_d;
      tick_q   <= tick_d;
      sync1_q  <= pad;
      sync2_q  <= sync1_q;
    end
  end

  assign raw         = sync2_q;
  assign s_vec       = raw ^ ACTIVE_LOW;
  assign sample_tick = tick_q;

  for (genvar i = 0; i < SIZE; i++) begin : g_ch
    assign pad[i] = pad_oe_q[i] ? ACTIVE_LOW[i] : 1'bz;

    io_input_conditioner_debounce_channel #(
      .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick_q),
      .s     (s_vec[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner: scan timing, debounce, polarity, reset.
module tb_io_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] tb_val;
  logic [3:0] tb_oe;
  wire  [3:0] pad;
  logic [3:0] level, rise, fall;
  logic       sample_tick;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [3:0] exp_level;

  always #5 clk = ~clk;

  // Bench side of each pad: stands in for the board pull / user press.
  for (genvar i = 0; i < 4; i++) begin : g_pad
    assign pad[i] = tb_oe[i] ? tb_val[i] : 1'bz;
  end

  io_input_conditioner #(
    .SIZE             (4),
    .EMULATE          (4'b0111),
    .ACTIVE_LOW       (4'b0100),
    .DRIVE_CYCLES     (2),
    .SETTLE_CYCLES    (4),
    .DEBOUNCE_SAMPLES (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pad         (pad),
    .level       (level),
    .rise        (rise),
    .fall        (fall),
    .sample_tick (sample_tick)
  );

  task automatic check_val(input string tag, input logic [3:0] act, input logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", tag, cyc, act, req);
    end
  endtask

  task automatic check_cycle(input logic [3:0] er, input logic [3:0] ef);
    logic [3:0] eoe;
    logic [3:0] etick;
    eoe   = (cyc >= 1 && (cyc % 7) <= 1) ? 4'b0111 : 4'b0000;
    etick = ((cyc % 7) == 6) ? 4'b0001 : 4'b0000;
    check_val("tick",  {3'b000, sample_tick}, etick);
    check_val("oe",    dut.pad_oe_q, eoe);
    check_val("level", level, exp_level);
    check_val("rise",  rise, er);
    check_val("fall",  fall, ef);
  endtask

  task automatic check_reset_zero(input string tag);
    check_val({tag, "_oe"},    dut.pad_oe_q, 4'b0000);
    check_val({tag, "_tick"},  {3'b000, sample_tick}, 4'b0000);
    check_val({tag, "_level"}, level, 4'b0000);
    check_val({tag, "_rise"},  rise, 4'b0000);
    check_val({tag, "_fall"},  fall, 4'b0000);
  endtask

  // Advance to cycle 'upto', checking every cycle against one optional rise and fall event.
  task automatic span(input int upto, input int r_at, input logic [3:0] r_m,
                      input int f_at, input logic [3:0] f_m);
    logic [3:0] er, ef;
    while (cyc < upto) begin
      @(negedge clk);
      cyc++;
      er = (cyc == r_at) ? r_m : 4'b0000;
      ef = (cyc == f_at) ? f_m : 4'b0000;
      exp_level = (exp_level | er) & ~ef;
      check_cycle(er, ef);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    tb_oe     = 4'b1111;
    tb_val    = 4'b0100;
    exp_level = 4'b0000;
    repeat (3) @(negedge clk);
    check_reset_zero("por");

    rst_n = 1'b1;
    cyc   = 0;
    check_cycle(4'b0000, 4'b0000);
    span(52, -1, 4'b0000, -1, 4'b0000);

    tb_val[0] = 1'b1;
    span(78, 70, 4'b0001, -1, 4'b0000);

    tb_val[1] = 1'b1;
    span(84, -1, 4'b0000, -1, 4'b0000);
    tb_val[1] = 1'b0;
    span(92, -1, 4'b0000, -1, 4'b0000);
    tb_val[1] = 1'b1;
    span(115, 112, 4'b0010, -1, 4'b0000);

    tb_val[2] = 1'b0;
    span(136, 133, 4'b0100, -1, 4'b0000);
    tb_val[2] = 1'b1;
    span(158, -1, 4'b0000, 154, 4'b0100);

    tb_val[0] = 1'b0;
    tb_val[1] = 1'b0;
    span(178, -1, 4'b0000, 175, 4'b0011);
    tb_val[0] = 1'b1;
    tb_val[3] = 1'b1;
    span(201, 196, 4'b1001, -1, 4'b0000);
    tb_val[3] = 1'b0;
    span(227, -1, 4'b0000, 224, 4'b1000);
    check_val("pre_rst_level", level, 4'b0001);

    rst_n = 1'b0;
    #1;
    check_reset_zero("rst_now");
    repeat (10) begin
      @(negedge clk);
      check_reset_zero("rst_hold");
    end

    @(negedge clk);
    rst_n     = 1'b1;
    cyc       = 0;
    exp_level = 4'b0000;
    check_cycle(4'b0000, 4'b0000);
    span(25, 21, 4'b0001, -1, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
